// File: rtl/muldiv_ctrl.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer that owns the HI/LO write port.
// Optional MULDIV_FAST_MULT_EN replaces the 32-step multiply loop with a single-cycle product.
module muldiv_ctrl #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [1:0]           op,
  input  logic [WIDTH-1:0]     src_a,
  input  logic [WIDTH-1:0]     src_b,
  input  logic                 flush,
  input  logic                 hilo_read,
  input  logic                 hilo_mt,
  output logic                 busy,
  output logic                 stall,
  output logic                 hilo_we,
  output logic [2*WIDTH-1:0]   hilo_wdata
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]         state;
  logic [CNT_W-1:0]   cnt;
  logic               op_div;
  logic               sign_a;
  logic               sign_b;
  logic               b_zero;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [2*WIDTH-1:0] acc;

  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   in_a_mag;
  logic [WIDTH-1:0]   in_b_mag;

  logic [WIDTH:0]     mult_sum;
  logic [2*WIDTH-1:0] mult_next;
  logic [2*WIDTH:0]   div_shift;
  logic [WIDTH+1:0]   div_diff;
  logic [2*WIDTH-1:0] div_next;

  logic [WIDTH-1:0]   quot;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   a_orig;
  logic [2*WIDTH-1:0] fix_result;

  assign busy    = (state != S_IDLE);
  assign hilo_we = (state == S_DONE);
  assign stall   = busy & (hilo_read | hilo_mt | start);

  // Magnitudes only for the signed ops (op[0]==0)
  assign a_neg    = ~op[0] & src_a[WIDTH-1];
  assign b_neg    = ~op[0] & src_b[WIDTH-1];
  assign in_a_mag = a_neg ? -src_a : src_a;
  assign in_b_mag = b_neg ? -src_b : src_b;

  assign mult_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, a_mag} : '0);
  assign mult_next = {mult_sum, acc[WIDTH-1:1]};

  assign div_shift = {acc, 1'b0};
  assign div_diff  = {1'b0, div_shift[2*WIDTH:WIDTH]} - {2'b00, b_mag};
  assign div_next  = div_diff[WIDTH+1] ? div_shift[2*WIDTH-1:0]
                                       : {div_diff[WIDTH-1:0], div_shift[WIDTH-1:1], 1'b1};

  assign quot   = acc[WIDTH-1:0];
  assign rem    = acc[2*WIDTH-1:WIDTH];
  assign a_orig = sign_a ? -a_mag : a_mag;

  always_comb begin
    fix_result = '0;
    if (op_div) begin
      if (b_zero)
        fix_result = {a_orig, {WIDTH{1'b1}}};
      else
        fix_result = {(sign_a ? -rem : rem), ((sign_a ^ sign_b) ? -quot : quot)};
    end else begin
      fix_result = (sign_a ^ sign_b) ? -acc : acc;
    end
  end

`ifdef MULDIV_FAST_MULT_EN
  logic signed [2*WIDTH+1:0] fast_full;
  assign fast_full = $signed({{(WIDTH+2){1'b0}}, a_mag}) * $signed({{(WIDTH+2){1'b0}}, b_mag});
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cnt        <= '0;
      op_div     <= 1'b0;
      sign_a     <= 1'b0;
      sign_b     <= 1'b0;
      b_zero     <= 1'b0;
      a_mag      <= '0;
      b_mag      <= '0;
      acc        <= '0;
      hilo_wdata <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start && !flush) begin
            op_div <= op[1];
            sign_a <= a_neg;
            sign_b <= b_neg;
            a_mag  <= in_a_mag;
            b_mag  <= in_b_mag;
            b_zero <= (src_b == '0);
            cnt    <= '0;
            acc    <= {{WIDTH{1'b0}}, (op[1] ? in_a_mag : in_b_mag)};
            state  <= S_CALC;
`ifdef MULDIV_FAST_MULT_EN
            if (!op[1])
              state <= S_FIX;
`endif
          end
        end
        S_CALC: begin
          if (flush) begin
            state <= S_IDLE;
          end else begin
            acc <= op_div ? div_next : mult_next;
            cnt <= cnt + 1'b1;
            if (cnt == CNT_W'(WIDTH - 1))
              state <= S_FIX;
          end
        end
        S_FIX: begin
          if (flush) begin
            state <= S_IDLE;
          end else begin
`ifdef MULDIV_FAST_MULT_EN
            // Fast multiply spends two FIX cycles: product capture (cnt==0), then sign fix.
            if (!op_div && cnt == '0) begin
              acc <= fast_full[2*WIDTH-1:0];
              cnt <= CNT_W'(1);
            end else begin
              hilo_wdata <= fix_result;
              state      <= S_DONE;
            end
`else
            hilo_wdata <= fix_result;
            state      <= S_DONE;
`endif
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
